// File: rtl/imem_loader.sv
// imem_loader: decodes host command bytes, loads 32-bit instruction words into memory and runs/steps the core.
// Build option IMEM_LOADER_CHECKSUM_EN adds an XOR checksum trailer byte after the halt word.
module imem_loader #(
  parameter int                MEM_SIZE  = 1024,
  parameter int                NBITS     = 32,
  parameter int                ADDR_BITS = $clog2(MEM_SIZE),
  parameter logic [NBITS-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_imem_we,
  output logic [ADDR_BITS-1:0] o_imem_addr,
  output logic [NBITS-1:0]     o_imem_data,
  output logic                 o_cpu_rst,
  output logic                 o_cpu_en,
  input  logic                 i_cpu_halt,
  output logic                 o_busy
);

  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_RUN    = 8'h02;
  localparam logic [7:0] CMD_STEP   = 8'h03;
  localparam logic [7:0] ST_OK      = 8'hA5;
  localparam logic [7:0] ST_STEP    = 8'h5A;
  localparam logic [7:0] ST_OVF     = 8'hEF;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_STEP,
    S_ACK
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_BITS-1:0]  addr_reg, addr_next;
  logic [NBITS-1:0]      word_reg, word_next;
  logic [1:0]            byte_cnt_reg, byte_cnt_next;
  logic [7:0]            status_reg, status_next;
  logic                  cpu_rst_reg, cpu_rst_next;
  logic                  rx_accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [7:0] ST_CHK_ERR = 8'hE1;
  logic [7:0]            chk_reg, chk_next;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      word_reg     <= '0;
      byte_cnt_reg <= '0;
      status_reg   <= '0;
      cpu_rst_reg  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      word_reg     <= word_next;
      byte_cnt_reg <= byte_cnt_next;
      status_reg   <= status_next;
      cpu_rst_reg  <= cpu_rst_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_reg      <= chk_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    word_next     = word_reg;
    byte_cnt_next = byte_cnt_reg;
    status_next   = status_reg;
    cpu_rst_next  = cpu_rst_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_next      = chk_reg;
`endif
    rx_accept     = 1'b0;
    o_imem_we     = 1'b0;
    o_cpu_en      = 1'b0;
    o_tx_valid    = 1'b0;
    o_tx_data     = 8'h00;

    case (state_reg)
      S_IDLE: begin
        rx_accept = 1'b1;
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_next    = S_LOAD;
              cpu_rst_next  = 1'b1;
              addr_next     = '0;
              byte_cnt_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              chk_next      = '0;
`endif
            end
            CMD_RUN: begin
              state_next   = S_RUN;
              cpu_rst_next = 1'b0;
            end
            CMD_STEP: begin
              state_next   = S_STEP;
              cpu_rst_next = 1'b0;
            end
            default: ;
          endcase
        end
      end

      S_LOAD: begin
        rx_accept = 1'b1;
        if (i_rx_valid) begin
          // MSB-first byte order: shift the new byte in at the bottom
          word_next     = {word_reg[NBITS-9:0], i_rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_next      = chk_reg ^ i_rx_data;
`endif
          if (byte_cnt_reg == 2'd3) begin
            state_next = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        o_imem_we = 1'b1;
        if (word_reg == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next  = S_CHK;
`else
          state_next  = S_ACK;
          status_next = ST_OK;
`endif
        end else if (addr_reg == LAST_ADDR) begin
          state_next  = S_ACK;
          status_next = ST_OVF;
        end else begin
          addr_next  = addr_reg + ADDR_BITS'(1);
          state_next = S_LOAD;
        end
      end

      S_RUN: begin
        // Halt gates the enable in the same cycle so no instruction past HALT advances
        o_cpu_en = !i_cpu_halt;
        if (i_cpu_halt) begin
          state_next  = S_ACK;
          status_next = ST_OK;
        end
      end

      S_STEP: begin
        o_cpu_en    = !i_cpu_halt;
        status_next = i_cpu_halt ? ST_OK : ST_STEP;
        state_next  = S_ACK;
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        rx_accept = 1'b1;
        if (i_rx_valid) begin
          status_next = (i_rx_data == chk_reg) ? ST_OK : ST_CHK_ERR;
          state_next  = S_ACK;
        end
      end
`endif

      S_ACK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = status_reg;
        if (i_tx_ready) begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Keep ready low while reset is held so no byte is consumed during reset
  assign o_rx_ready  = rx_accept & i_rst;
  assign o_imem_addr = addr_reg;
  assign o_imem_data = word_reg;
  assign o_cpu_rst   = cpu_rst_reg;
  assign o_busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with MEM_SIZE=4; honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam int MEM_SIZE  = 4;
  localparam int ADDR_BITS = 2;
  localparam int NBITS     = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_valid = 1'b0;
  logic                 rx_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b0;
  logic                 imem_we;
  logic [ADDR_BITS-1:0] imem_addr;
  logic [NBITS-1:0]     imem_data;
  logic                 cpu_rst;
  logic                 cpu_en;
  logic                 cpu_halt = 1'b0;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic [ADDR_BITS-1:0] wr_addr_q[$];
  logic [NBITS-1:0]     wr_data_q[$];

  imem_loader #(
    .MEM_SIZE (MEM_SIZE),
    .NBITS    (NBITS),
    .ADDR_BITS(ADDR_BITS),
    .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_imem_we  (imem_we),
    .o_imem_addr(imem_addr),
    .o_imem_data(imem_data),
    .o_cpu_rst  (cpu_rst),
    .o_cpu_en   (cpu_en),
    .i_cpu_halt (cpu_halt),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // Log every write strobe cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
      $display("imem write addr=%0d data=%08h", imem_addr, imem_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout byte=%02h ready=%b required 1", b, rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    $display("rx byte %02h", b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic wait_tx(output bit got);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    got = (tx_valid === 1'b1);
    $display("tx pending valid=%b data=%02h", tx_valid, tx_data);
  endtask

  task automatic tx_accept();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    checks++;
    if ({busy, rx_ready, tx_valid, imem_we, cpu_en} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%05b exp=00000", {busy, rx_ready, tx_valid, imem_we, cpu_en});
    end
    checks++;
    if ({tx_data, imem_addr, imem_data} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", tx_data, imem_addr, imem_data);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, busy, cpu_rst} !== 3'b101) begin
      errors++; $display("FAIL idle_state got=%03b exp=101", {rx_ready, busy, cpu_rst});
    end
    checks++;
    if (wr_addr_q.size() != 0) begin errors++; $display("FAIL reset_no_write got=%0d exp=0", wr_addr_q.size()); end
    $display("test_reset done");
  endtask

  task automatic test_load_two_words();
    bit got;
    int bad;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h01);
    checks++;
    if ({busy, cpu_rst} !== 2'b11) begin errors++; $display("FAIL load_entry got=%02b exp=11", {busy, cpu_rst}); end
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    checks++;
    if ({imem_we, imem_addr, imem_data} !== {1'b1, 2'd0, 32'h20010005}) begin
      errors++; $display("FAIL write_latency got we=%b addr=%0d data=%08h exp we=1 addr=0 data=20010005", imem_we, imem_addr, imem_data);
    end
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL write_rx_ready got=%b exp=0", rx_ready); end
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b0) begin errors++; $display("FAIL write_single_pulse got=%b exp=0", imem_we); end
    send_word(32'hFFFFFFFF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h24);
`endif
    wait_tx(got);
    checks++;
    if (!got || tx_data !== 8'hA5) begin errors++; $display("FAIL load_status got valid=%b data=%02h exp=a5", tx_valid, tx_data); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || rx_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tx_hold bad_cycles=%0d exp=0 (valid=%b data=%02h)", bad, tx_valid, tx_data); end
    tx_accept();
    checks++;
    if ({busy, tx_valid, cpu_rst} !== 3'b001) begin
      errors++; $display("FAIL after_ack got=%03b exp=001", {busy, tx_valid, cpu_rst});
    end
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 2'd0 || wr_data_q[0] !== 32'h20010005
        || wr_addr_q[1] !== 2'd1 || wr_data_q[1] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL load_writes got count=%0d exp 2 writes {0:20010005,1:ffffffff}", wr_addr_q.size());
    end
    $display("test_load_two_words done");
  endtask

  task automatic test_overflow();
    bit got;
    int bad;
    logic [31:0] words [4];
    words[0] = 32'h10203040;
    words[1] = 32'h0A0B0C0D;
    words[2] = 32'h12345678;
    words[3] = 32'hDEADBEEF;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_word(words[i]);
    wait_tx(got);
    checks++;
    if (!got || tx_data !== 8'hEF) begin errors++; $display("FAIL overflow_status got valid=%b data=%02h exp=ef", tx_valid, tx_data); end
    tx_accept();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL overflow_idle got busy=%b exp=0", busy); end
    bad = 0;
    if (wr_addr_q.size() != 4) bad = 99;
    else for (int i = 0; i < 4; i++) if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== words[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL overflow_writes count=%0d bad=%0d exp 4 writes addr0..3", wr_addr_q.size(), bad); end
    $display("test_overflow done");
  endtask

  task automatic test_unknown_cmd();
    send_byte(8'h55);
    checks++;
    if ({busy, rx_ready, cpu_rst} !== 3'b011) begin
      errors++; $display("FAIL unknown_cmd got=%03b exp=011", {busy, rx_ready, cpu_rst});
    end
    $display("test_unknown_cmd done");
  endtask

  task automatic test_run_to_halt();
    bit got;
    int bad;
    send_byte(8'h02);
    bad = 0;
    for (int c = 1; c <= 19; c++) begin
      if (cpu_en !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL run_enable low_cycles=%0d exp=0", bad); end
    checks++;
    if ({cpu_rst, rx_ready} !== 2'b00) begin errors++; $display("FAIL run_ctrl got=%02b exp=00", {cpu_rst, rx_ready}); end
    cpu_halt = 1'b1;
    #1;
    checks++;
    if ({cpu_en, busy} !== 2'b01) begin errors++; $display("FAIL run_halt_gate got en=%b busy=%b exp en=0 busy=1", cpu_en, busy); end
    @(negedge clk);
    wait_tx(got);
    checks++;
    if (!got || tx_data !== 8'hA5 || cpu_en !== 1'b0) begin
      errors++; $display("FAIL run_status got valid=%b data=%02h en=%b exp=a5 en=0", tx_valid, tx_data, cpu_en);
    end
    tx_accept();
    cpu_halt = 1'b0;
    $display("test_run_to_halt done");
  endtask

  task automatic test_step();
    bit got;
    send_byte(8'h03);
    checks++;
    if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_pulse got=%b exp=1", cpu_en); end
    @(negedge clk);
    checks++;
    if ({cpu_en, tx_valid, tx_data} !== {1'b0, 1'b1, 8'h5A}) begin
      errors++; $display("FAIL step_status got en=%b valid=%b data=%02h exp en=0 valid=1 data=5a", cpu_en, tx_valid, tx_data);
    end
    tx_accept();
    cpu_halt = 1'b1;
    send_byte(8'h03);
    checks++;
    if (cpu_en !== 1'b0) begin errors++; $display("FAIL step_halted_en got=%b exp=0", cpu_en); end
    wait_tx(got);
    checks++;
    if (!got || tx_data !== 8'hA5) begin errors++; $display("FAIL step_halted_status got=%02b/%02h exp=a5", tx_valid, tx_data); end
    tx_accept();
    cpu_halt = 1'b0;
    $display("test_step done");
  endtask

  task automatic test_reset_during_load();
    bit got;
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, imem_we, cpu_rst} !== 3'b001) begin
      errors++; $display("FAIL mid_load_reset got=%03b exp=001", {busy, imem_we, cpu_rst});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 0) begin errors++; $display("FAIL mid_load_no_write got=%0d exp=0", wr_addr_q.size()); end
    send_byte(8'h01);
    send_word(32'h00000007);
    send_word(32'hFFFFFFFF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h07);
`endif
    wait_tx(got);
    checks++;
    if (!got || tx_data !== 8'hA5) begin errors++; $display("FAIL reload_status got=%b/%02h exp=a5", tx_valid, tx_data); end
    tx_accept();
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 2'd0 || wr_data_q[0] !== 32'h00000007) begin
      errors++; $display("FAIL reload_writes count=%0d exp 2, first exp addr0=00000007", wr_addr_q.size());
    end
    $display("test_reset_during_load done");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit got;
    send_byte(8'h01);
    send_word(32'h00000001);
    send_word(32'hFFFFFFFF);
    send_byte(8'h01);
    wait_tx(got);
    checks++;
    if (!got || tx_data !== 8'hA5) begin errors++; $display("FAIL chk_match got=%b/%02h exp=a5", tx_valid, tx_data); end
    tx_accept();
    send_byte(8'h01);
    send_word(32'h00000001);
    send_word(32'hFFFFFFFF);
    send_byte(8'h02);
    wait_tx(got);
    checks++;
    if (!got || tx_data !== 8'hE1) begin errors++; $display("FAIL chk_mismatch got=%b/%02h exp=e1", tx_valid, tx_data); end
    tx_accept();
    $display("test_checksum done");
  endtask
`endif

  initial begin
    test_reset();
    test_load_two_words();
    test_overflow();
    test_unknown_cmd();
    test_run_to_halt();
    test_step();
    test_reset_during_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory read interface used by the pipelined datapath.
- Takes a byte stream (UART receiver side, valid/ready) and decodes host commands.
- Assembles 32-bit instruction words and writes them into instruction memory, then controls processor run/step and returns a status byte on a transmit handshake.
- Sits between the UART debug front-end and the datapath (instruction memory write port, processor enable/reset).

Parameters:
- MEM_SIZE, 1024, instruction memory depth in words.
- NBITS, 32, instruction word width; exactly 4 bytes.
- ADDR_BITS, 10, word-address width; clog2(MEM_SIZE).
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is written to memory.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  byte available.
- o_rx_ready  out  1  loader accepts byte; transfer when valid&ready.
- o_tx_data  out  8  status byte to host.
- o_tx_valid  out  1  status byte pending.
- i_tx_ready  in  1  transmitter accepts; transfer when valid&ready.
- o_imem_we  out  1  instruction memory write strobe, one cycle per word.
- o_imem_addr  out  ADDR_BITS  word address.
- o_imem_data  out  NBITS  word to write.
- o_cpu_rst  out  1  active-high hold of processor in reset.
- o_cpu_en  out  1  processor clock-enable (write_pc/pipeline advance).
- i_cpu_halt  in  1  processor retired HALT_WORD.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst=0, async) state:
  - State IDLE; all outputs 0 except o_cpu_rst=1.
  - Address counter 0, byte counter 0, checksum 0.
- States: IDLE, LOAD, WRITE, RUN, STEP, ACK.
- IDLE: o_rx_ready=1. Command byte decoding:
  - 0x01 -> LOAD; o_cpu_rst=1, addr=0.
  - 0x02 -> RUN; o_cpu_rst=0.
  - 0x03 -> STEP; o_cpu_rst=0.
  - Any other byte is dropped and the block stays in IDLE.
- LOAD: o_rx_ready=1. Bytes arrive MSB first and shift into the word register; byte counter counts 0..3. When the 4th byte is accepted, go to WRITE.
- WRITE: o_rx_ready=0 for exactly one cycle. o_imem_we=1 with o_imem_addr=addr and o_imem_data=word. Next state:
  - word==HALT_WORD -> ACK, status 0xA5.
  - addr==MEM_SIZE-1 and word!=HALT_WORD -> ACK, status 0xEF (overflow); memory contents are kept.
  - Otherwise addr+1 and return to LOAD.
- Write latency: 1 cycle after the 4th byte handshake. Exactly one write per word.
- RUN: o_cpu_en=1 continuously, o_rx_ready=0. When i_cpu_halt=1, o_cpu_en drops in the same cycle (combinational gate), then ACK with status 0xA5.
- STEP: o_cpu_en=1 for exactly one cycle, then ACK with status 0x5A. If i_cpu_halt is already 1 on entry, o_cpu_en stays 0 and status is 0xA5.
- ACK: o_tx_valid=1 and o_tx_data hold steady until i_tx_ready=1, then IDLE. o_rx_ready=0 while in ACK.
- o_cpu_rst stays at its last value from the end of LOAD; it is only re-asserted by the next 0x01 command.
- Reset during any state returns to IDLE at once. A partial word is discarded and no write strobe is produced.
- Bytes offered while o_rx_ready=0 are not consumed; the source holds them.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Every byte accepted in LOAD, including HALT_WORD bytes, is XORed into an 8-bit checksum.
  - After the HALT_WORD write, a state CHK takes one more byte.
  - If that byte equals the checksum, status is 0xA5; otherwise 0xE1.
  - The checksum is cleared when the 0x01 command is received.
  - The overflow path skips CHK.
- Undefined: no CHK state, no checksum logic; status after load is always 0xA5 (or 0xEF on overflow).

Test Plan:
- Reset then idle: hold i_rst=0 then release -> o_cpu_rst=1, o_busy=0, o_imem_we never pulses, o_rx_ready=1.
- Load two words: send 0x01, 0x20,0x01,0x00,0x05, 0xFF×4 ->
  - write addr0=0x20010005, then addr1=0xFFFFFFFF, each a single we pulse.
  - tx 0xA5; hold i_tx_ready=0 for 3 cycles -> o_tx_valid and data held.
- Overflow: MEM_SIZE=4, send 0x01 plus 4 non-halt words -> writes at addr0..3, tx 0xEF, return to IDLE.
- Run to halt: send 0x02, assert i_cpu_halt at cycle 20 -> o_cpu_en high for cycles 1..19, low at 20, tx 0xA5.
- Step and reset: send 0x03 -> o_cpu_en one-cycle pulse, tx 0x5A. During LOAD, after 2 bytes, assert i_rst -> state IDLE, no write.
- Checksum (macro defined): load 0x00000001 plus HALT_WORD; send trailer 0x01 -> 0xA5; send trailer 0x02 -> 0xE1.
